// File: rtl/spi_adc_slave.sv
// SPI mode-0 slave: returns the latest ADC sample MSB first on MISO and captures
// a 16-bit LSB-first MOSI word. All SPI inputs are oversampled in the CLK_IN domain.
module spi_adc_slave #(
   parameter int SAMPLE_W    = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                CLK_IN,
   input  logic                XRES_IN,
   input  logic [SAMPLE_W-1:0] adc_data,
   input  logic                adc_valid,
   input  logic                SCLK,
   input  logic                SS,
   input  logic                MOSI,
   output logic                MISO,
   output logic [15:0]         rx_data,
   output logic                rx_valid,
   output logic                frame_err,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT_SS_HIGH} state_t;

   localparam int FILL_W = $clog2(SYNC_STAGES + 1);

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic [FILL_W-1:0]      fill_cnt;
   logic                   sync_full;
   logic                   sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;
   logic                   start_frame;
   logic [SAMPLE_W-1:0]    sample;
   logic [15:0]            tx_sr, rx_sr;
   logic [4:0]             bit_cnt;
   logic                   overrun, seen_rise;

   // NOTE: every clocked process uses non-blocking assignments so all flops
   // sample pre-edge values and simulation order between processes never matters.
   always_ff @(posedge CLK_IN or negedge XRES_IN) begin
      if (!XRES_IN) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         fill_cnt  <= '0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
         if (!sync_full) fill_cnt <= fill_cnt + 1'b1;
      end
   end

   // Reset values of the SS chain are not real samples; leaving WAIT_SS_HIGH
   // needs a pipeline refilled with a genuinely high SS.
   assign sync_full = (fill_cnt == FILL_W'(SYNC_STAGES));
   assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
   assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];
   assign ss_rise   = ss_sync[SYNC_STAGES-2] & ~ss_sync[SYNC_STAGES-1];
   assign ss_fall   = ~ss_sync[SYNC_STAGES-2] & ss_sync[SYNC_STAGES-1];
   assign mosi_bit  = mosi_sync[SYNC_STAGES-2];

   always_ff @(posedge CLK_IN or negedge XRES_IN) begin
      if (!XRES_IN) state <= WAIT_SS_HIGH;
      else          state <= state_nxt;
   end

   // NOTE: the default assignment ahead of the case keeps this block free of latches.
   always_comb begin
      state_nxt = state;
      unique case (state)
         WAIT_SS_HIGH: if (sync_full && (&ss_sync)) state_nxt = IDLE;
         IDLE:         if (ss_fall) state_nxt = SHIFT;
         SHIFT:        if (ss_rise) state_nxt = IDLE;
         default:      state_nxt = WAIT_SS_HIGH;
      endcase
   end

   always_comb begin
      busy = (state == SHIFT);
      MISO = (state == SHIFT) ? tx_sr[15] : 1'b0;
   end

   assign start_frame = (state == IDLE) && ss_fall;

   always_ff @(posedge CLK_IN or negedge XRES_IN) begin
      if (!XRES_IN) begin
         sample    <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         bit_cnt   <= '0;
         overrun   <= 1'b0;
         seen_rise <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (adc_valid) sample <= adc_data;
         if (start_frame) begin
            // A strobe coinciding with SS fall must reach this frame directly.
            tx_sr     <= 16'(adc_valid ? adc_data : sample);
            rx_sr     <= '0;
            bit_cnt   <= '0;
            overrun   <= 1'b0;
            seen_rise <= 1'b0;
         end else if (state == SHIFT) begin
            if (sclk_rise) begin
               seen_rise <= 1'b1;
               if (bit_cnt == 5'd16) begin
                  overrun <= 1'b1;
               end else begin
                  rx_sr[bit_cnt[3:0]] <= mosi_bit;
                  bit_cnt             <= bit_cnt + 5'd1;
               end
            end
            if (sclk_fall && seen_rise) tx_sr <= {tx_sr[14:0], 1'b0};
            if (ss_rise) begin
               if (bit_cnt == 5'd16 && !overrun) begin
                  rx_data  <= rx_sr;
                  rx_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_adc_slave.sv
// Randomized SPI master driving spi_adc_slave, checked against a frame-level
// model (latest sample, expected rx word, strobe counts).
`timescale 1ns/1ps
module tb_spi_adc_slave;
   localparam int SAMPLE_W    = 12;
   localparam int SYNC_STAGES = 2;
   localparam int HALF_MIN    = SYNC_STAGES + 2;
   localparam int HALF_250    = 6;   // 250 ns at 24 MHz

   logic                CLK_IN    = 1'b0;
   logic                XRES_IN   = 1'b0;
   logic [SAMPLE_W-1:0] adc_data  = '0;
   logic                adc_valid = 1'b0;
   logic                SCLK      = 1'b0;
   logic                SS        = 1'b1;
   logic                MOSI      = 1'b0;
   logic                MISO, rx_valid, frame_err, busy;
   logic [15:0]         rx_data;

   int vectors     = 0;
   int miscompares = 0;

   // Behavioural model state
   logic [SAMPLE_W-1:0] model_sample = '0;
   logic [15:0]         exp_rx_data  = '0;
   logic [15:0]         pend_word    = '0;
   bit                  pend_good    = 1'b0;
   int                  n_valid      = 0;
   int                  n_err        = 0;

   spi_adc_slave #(.SAMPLE_W(SAMPLE_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .CLK_IN    (CLK_IN),
      .XRES_IN   (XRES_IN),
      .adc_data  (adc_data),
      .adc_valid (adc_valid),
      .SCLK      (SCLK),
      .SS        (SS),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #21 CLK_IN = ~CLK_IN;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle compare against the model.
   always @(negedge CLK_IN) begin
      if (!XRES_IN) begin
         exp_rx_data = '0;
         check("reset_outputs", {12'd0, MISO, busy, rx_valid, frame_err, rx_data}, 32'd0);
      end else begin
         if (rx_valid) begin
            n_valid++;
            check("rx_valid_expected", 32'(pend_good), 32'd1);
            if (pend_good) exp_rx_data = pend_word;
            pend_good = 1'b0;
         end
         if (frame_err) n_err++;
         check("rx_data", 32'(rx_data), 32'(exp_rx_data));
         if (!busy) check("miso_idle", 32'(MISO), 32'd0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK_IN);
   endtask

   task automatic adc_pulse(input logic [SAMPLE_W-1:0] d);
      @(negedge CLK_IN);
      adc_data = d; adc_valid = 1'b1; model_sample = d;
      @(negedge CLK_IN);
      adc_valid = 1'b0; adc_data = SAMPLE_W'($urandom);
   endtask

   task automatic sclk_pulses(input int n, input int half);
      for (int i = 0; i < n; i++) begin
         SCLK = 1'b1; MOSI = 1'($urandom);
         repeat (half) @(negedge CLK_IN);
         SCLK = 1'b0;
         repeat (half) @(negedge CLK_IN);
      end
   endtask

   // One master frame; returns the MISO bits the master sampled (MSB first).
   task automatic spi_frame(input int nclk, input logic [15:0] mosi_word, input int half,
                            input bit at_fall, input logic [SAMPLE_W-1:0] fall_data,
                            input int mid_bit, input logic [SAMPLE_W-1:0] mid_data,
                            output logic [15:0] got);
      logic [15:0] frame_word, mask;
      int          extra_ones;
      got = '0; extra_ones = 0;
      @(negedge CLK_IN);
      n_valid = 0; n_err = 0;
      SS = 1'b0; MOSI = mosi_word[0];
      if (at_fall) begin
         // Land the strobe on the edge where the synchronized SS fall is seen.
         repeat (SYNC_STAGES - 1) @(posedge CLK_IN);
         @(negedge CLK_IN);
         adc_data = fall_data; adc_valid = 1'b1; model_sample = fall_data;
         @(negedge CLK_IN);
         adc_valid = 1'b0;
      end
      frame_word = 16'(model_sample);
      repeat (half) @(negedge CLK_IN);
      check("busy_in_frame", 32'(busy), 32'd1);
      for (int i = 0; i < nclk; i++) begin
         if (i < 16) got[15-i] = MISO;
         else if (MISO) extra_ones++;
         SCLK = 1'b1;
         if (i == mid_bit) begin
            adc_data = mid_data; adc_valid = 1'b1; model_sample = mid_data;
            @(negedge CLK_IN);
            adc_valid = 1'b0;
            repeat (half - 1) @(negedge CLK_IN);
         end else begin
            repeat (half) @(negedge CLK_IN);
         end
         SCLK = 1'b0;
         MOSI = (i + 1 < 16) ? mosi_word[i+1] : 1'($urandom);
         repeat (half) @(negedge CLK_IN);
      end
      if (nclk >= 16) check("miso_after_16", 32'(MISO), 32'd0);
      mask = (nclk >= 16) ? 16'hFFFF : ~(16'hFFFF >> nclk);
      check("master_word", 32'(got & mask), 32'(frame_word & mask));
      check("miso_extra_bits", extra_ones, 0);
      pend_word = mosi_word;
      pend_good = (nclk == 16);
      SS = 1'b1;
      repeat (SYNC_STAGES + 6) @(negedge CLK_IN);
      check("rx_valid_count", n_valid, (nclk == 16) ? 1 : 0);
      check("frame_err_count", n_err, (nclk == 16) ? 0 : 1);
      check("busy_after_frame", 32'(busy), 32'd0);
      pend_good = 1'b0;
   endtask

   initial begin
      logic [15:0] w;

      idle(4);
      XRES_IN = 1'b1;
      idle(SYNC_STAGES + 4);
      check("busy_after_reset", 32'(busy), 32'd0);

      // One-hot sample sweep
      for (int x = 0; x < SAMPLE_W; x++) begin
         adc_pulse(SAMPLE_W'(1) << x);
         idle(2);
         spi_frame(16, 16'h5555, HALF_250, 1'b0, '0, -1, '0, w);
         check("onehot_word", 32'(w), 32'd1 << x);
         check("onehot_rx_data", 32'(rx_data), 32'h5555);
      end

      // Bypass at SS fall, then a mid-frame update
      spi_frame(16, 16'h1234, HALF_250, 1'b1, 12'hABC, -1, '0, w);
      check("fall_bypass_word", 32'(w), 32'h0ABC);
      spi_frame(16, 16'h4321, HALF_250, 1'b0, '0, 5, 12'h123, w);
      check("midframe_word", 32'(w), 32'h0ABC);
      spi_frame(16, 16'h0F0F, HALF_250, 1'b0, '0, -1, '0, w);
      check("next_frame_word", 32'(w), 32'h0123);

      // Short and long frames
      spi_frame(8, 16'hFFFF, HALF_250, 1'b0, '0, -1, '0, w);
      check("short_rx_data_held", 32'(rx_data), 32'h0F0F);
      spi_frame(17, 16'h00FF, HALF_250, 1'b0, '0, -1, '0, w);
      check("long_rx_data_held", 32'(rx_data), 32'h0F0F);

      // Reset in the middle of a frame, released with SS still low
      @(negedge CLK_IN);
      SS = 1'b0;
      idle(HALF_250);
      sclk_pulses(5, HALF_250);
      n_valid = 0; n_err = 0;
      #5 XRES_IN = 1'b0;
      model_sample = '0;
      idle(3);
      XRES_IN = 1'b1;
      idle(10);
      sclk_pulses(4, HALF_250);
      check("no_frame_after_reset", 32'(busy), 32'd0);
      check("aborted_strobes", n_valid + n_err, 0);
      SS = 1'b1;
      idle(SYNC_STAGES + 4);
      spi_frame(16, 16'hA5A5, HALF_250, 1'b0, '0, -1, '0, w);
      check("post_reset_rx_data", 32'(rx_data), 32'hA5A5);
      check("post_reset_word", 32'(w), 32'h0000);

      // SCLK activity with SS high
      n_valid = 0; n_err = 0;
      sclk_pulses(10, HALF_MIN);
      check("ss_high_busy", 32'(busy), 32'd0);
      check("ss_high_miso", 32'(MISO), 32'd0);
      check("ss_high_strobes", n_valid + n_err, 0);

      // Randomized frames
      for (int r = 0; r < 25; r++) begin
         int nclk, half, mid;
         nclk = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(1, 20));
         half = $urandom_range(HALF_MIN, HALF_MIN + 4);
         mid  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nclk - 1)) : -1;
         if ($urandom_range(0, 1) == 1) adc_pulse(SAMPLE_W'($urandom));
         spi_frame(nclk, 16'($urandom), half, $urandom_range(0, 3) == 0,
                   SAMPLE_W'($urandom), mid, SAMPLE_W'($urandom), w);
         idle($urandom_range(1, 5));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
